apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 155 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB master bridge; one registered response pulse per transfer.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT cycles.
module apb_master_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    complete;
  logic                    abort;
  logic                    accept;

  assign complete = (state_q == ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;

  assign abort = (state_q == ACCESS) && !pready && (wait_cnt_q == WAIT_LIMIT);

  // Counter restarts in SETUP so every ACCESS phase begins at zero.
  always_comb begin
    wait_cnt_d    = 8'd0;
    rsp_timeout_d = abort;
    if (state_q == ACCESS && !pready) begin
      wait_cnt_d = 8'(wait_cnt_q + 8'd1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt_q    <= 8'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT[0];
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) || complete;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = complete || abort;
    rsp_rdata_d = '0;
    rsp_err_d   = abort;

    case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (complete) begin
          state_d = accept ? SETUP : IDLE;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      rsp_err_d = pslverr;
      if (!pwrite_q) rsp_rdata_d = prdata;
    end

    if (accept) begin
      paddr_d  = req_addr;
      pwrite_d = req_write;
      pwdata_d = req_wdata;
    end

    // Bus strobes are registered copies of the next state's decode.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus randomized transfers
// against a transaction-level response queue. Timeout case runs when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TB_TIMEOUT = 4;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  rsp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  apb_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TB_TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle;
    @(posedge pclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBus(input string tag, input logic s, input logic e,
                          input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    checkOutput({tag, "_psel"}, psel, s);
    checkOutput({tag, "_penable"}, penable, e);
    checkOutput({tag, "_paddr"}, paddr, a);
    checkOutput({tag, "_pwrite"}, pwrite, w);
    checkOutput({tag, "_pwdata"}, pwdata, d);
  endtask

  task automatic checkNoRsp(input string tag);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b0);
  endtask

  task automatic checkRsp(input string tag);
    rsp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=response expected=empty_queue", tag);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b1);
      checkOutput({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
      checkOutput({tag, "_rsp_err"}, rsp_err, e.err);
      checkOutput({tag, "_rsp_timeout"}, rsp_timeout, e.tmo);
    end
  endtask

  // One complete transfer from IDLE back to IDLE; ends one cycle after the response pulse.
  task automatic applyStimulus(input string tag, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int waits,
                               input logic [DW-1:0] rdata, input logic err);
    rsp_t e;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; pready = 1'b0;
    #1;
    checkOutput({tag, "_ready_idle"}, req_ready, 1'b1);
    stepCycle;
    req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom); req_write = ~wr;
    checkBus({tag, "_setup"}, 1'b1, 1'b0, addr, wr, wdata);
    checkNoRsp({tag, "_setup"});
    stepCycle;
    for (int i = 0; i < waits; i++) begin
      pready = 1'b0; prdata = DW'($urandom); pslverr = 1'b1;
      #1;
      checkBus({tag, "_wait"}, 1'b1, 1'b1, addr, wr, wdata);
      checkOutput({tag, "_ready_wait"}, req_ready, 1'b0);
      checkNoRsp({tag, "_wait"});
      stepCycle;
    end
    pready = 1'b1; prdata = rdata; pslverr = err;
    #1;
    checkBus({tag, "_access"}, 1'b1, 1'b1, addr, wr, wdata);
    checkOutput({tag, "_ready_done"}, req_ready, 1'b1);
    e.rdata = wr ? '0 : rdata;
    e.err   = err;
    e.tmo   = 1'b0;
    expQ.push_back(e);
    stepCycle;
    pready = 1'b0; pslverr = 1'b0; prdata = DW'($urandom);
    checkRsp({tag, "_rsp"});
    checkOutput({tag, "_psel_after"}, psel, 1'b0);
    checkOutput({tag, "_penable_after"}, penable, 1'b0);
    stepCycle;
    checkNoRsp({tag, "_after"});
  endtask

  initial begin
    rsp_t e;
    logic [DW-1:0] rdata;

    // Reset state
    stepCycle;
    stepCycle;
    checkBus("reset", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkNoRsp("reset");
    checkOutput("reset_rdata", rsp_rdata, 8'h00);
    checkOutput("reset_err", rsp_err, 1'b0);
    checkOutput("reset_tmo", rsp_timeout, 1'b0);
    preset = 1'b0;
    stepCycle;

    // Reset asserted mid-ACCESS of a write to 0x10
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
    stepCycle;
    req_valid = 1'b0;
    stepCycle;
    checkBus("pre_reset_access", 1'b1, 1'b1, 8'h10, 1'b1, 8'hA5);
    preset = 1'b1;
    #1;
    checkBus("mid_reset", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkNoRsp("mid_reset");
    stepCycle;
    preset = 1'b0;
    checkNoRsp("mid_reset_next");
    stepCycle;
    checkNoRsp("post_reset");
    checkOutput("post_reset_psel", psel, 1'b0);

    // Directed transfers
    applyStimulus("wr10", 1'b1, 8'h10, 8'hA5, 0, 8'h77, 1'b0);
    applyStimulus("rd10", 1'b0, 8'h10, 8'h00, 3, 8'hA5, 1'b0);
    applyStimulus("rdC9err", 1'b0, 8'hC9, 8'h00, 0, 8'h3E, 1'b1);

    // Back-to-back: write 0x20 then read 0x21 (one wait state) with req_valid held high
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h3C;
    #1;
    checkOutput("b2b_ready_idle", req_ready, 1'b1);
    stepCycle;
    req_write = 1'b0; req_addr = 8'h21; req_wdata = 8'hD2;
    #1;
    checkOutput("b2b_ready_setup", req_ready, 1'b0);
    checkBus("b2b_setup1", 1'b1, 1'b0, 8'h20, 1'b1, 8'h3C);
    stepCycle;
    pready = 1'b1; pslverr = 1'b0; prdata = 8'hEE;
    #1;
    checkBus("b2b_access1", 1'b1, 1'b1, 8'h20, 1'b1, 8'h3C);
    checkOutput("b2b_ready_done1", req_ready, 1'b1);
    e.rdata = 8'h00; e.err = 1'b0; e.tmo = 1'b0;
    expQ.push_back(e);
    stepCycle;
    req_valid = 1'b0; pready = 1'b0;
    checkBus("b2b_setup2", 1'b1, 1'b0, 8'h21, 1'b0, 8'hD2);
    checkRsp("b2b_rsp1");
    stepCycle;
    checkBus("b2b_wait2", 1'b1, 1'b1, 8'h21, 1'b0, 8'hD2);
    checkNoRsp("b2b_wait2");
    stepCycle;
    pready = 1'b1; prdata = 8'h5A;
    checkBus("b2b_access2", 1'b1, 1'b1, 8'h21, 1'b0, 8'hD2);
    checkNoRsp("b2b_access2");
    e.rdata = 8'h5A; e.err = 1'b0; e.tmo = 1'b0;
    expQ.push_back(e);
    stepCycle;
    pready = 1'b0;
    checkRsp("b2b_rsp2");
    checkOutput("b2b_psel_end", psel, 1'b0);
    stepCycle;
    checkNoRsp("b2b_after");

`ifdef APB_TIMEOUT_EN
    // pready stuck low: abort after TB_TIMEOUT ACCESS cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h44; req_wdata = 8'h11;
    stepCycle;
    req_valid = 1'b0;
    stepCycle;
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      pready = 1'b0; prdata = DW'($urandom); pslverr = 1'b1;
      #1;
      checkBus("tmo_access", 1'b1, 1'b1, 8'h44, 1'b0, 8'h11);
      checkOutput("tmo_ready", req_ready, 1'b0);
      checkNoRsp("tmo_access");
      stepCycle;
    end
    pslverr = 1'b0;
    e.rdata = 8'h00; e.err = 1'b1; e.tmo = 1'b1;
    expQ.push_back(e);
    checkRsp("tmo_rsp");
    checkOutput("tmo_psel", psel, 1'b0);
    checkOutput("tmo_penable", penable, 1'b0);
    stepCycle;
    checkNoRsp("tmo_after");
    applyStimulus("tmo_next", 1'b1, 8'h45, 8'h99, 1, 8'h00, 1'b0);
`endif

    // Randomized transfers with optional idle gaps
    for (int n = 0; n < 24; n++) begin
      rdata = DW'($urandom);
      applyStimulus("rand", 1'($urandom), AW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 2)), rdata, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        stepCycle;
        checkOutput("rand_gap_psel", psel, 1'b0);
        checkNoRsp("rand_gap");
      end
    end

    checkOutput("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
